// File: rtl/skel_pass_scheduler.sv
// Skeletonization pass sequencer: host image load, mask read-address sweeps, write-port arbitration.
// Define SKEL_CONVERGE_EN to end a job early on the first pass that changes no pixel.
`timescale 1ns/1ps

module skel_pass_scheduler #(
    parameter int unsigned N          = 8,
    parameter int unsigned bitSize    = 6,
    parameter int unsigned pixelWidth = 8,
    parameter int unsigned MAX_PASSES = 16,
    parameter int unsigned MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  host_we,
    input  logic [pixelWidth-1:0] host_data,
    output logic                  host_ready,
    output logic                  mask_req,
    output logic [bitSize:0]      mask_addr,
    input  logic                  mask_ack,
    input  logic                  mask_wr_valid,
    input  logic [bitSize:0]      mask_wr_addr,
    input  logic [pixelWidth-1:0] mask_wr_data,
    output logic                  ram_we,
    output logic [bitSize:0]      ram_addr,
    output logic [pixelWidth-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            pass_count,
    output logic                  err
);

    localparam int unsigned AW = bitSize + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam logic [AW-1:0] LastAddr  = AW'(N * N - 1);
    localparam logic [AW-1:0] CntMax    = '1;
    localparam logic [OW-1:0] MaxOut    = OW'(MAX_OUT);
    localparam logic [7:0]    MaxPasses = 8'(MAX_PASSES);
`ifdef SKEL_CONVERGE_EN
    localparam bit ConvergeEn = 1'b1;
`else
    localparam bit ConvergeEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StLoad, StScan, StDrain, StCheck, StDone} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         load_addr_q, load_addr_d;
    logic [AW-1:0]         scan_addr_q, scan_addr_d;
    logic                  sweep_done_q, sweep_done_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic [AW-1:0]         change_cnt_q, change_cnt_d;
    logic [7:0]            pass_count_q, pass_count_d;
    logic                  err_q, err_d;
    logic                  mask_req_q, mask_req_d;
    logic [AW-1:0]         mask_addr_q, mask_addr_d;
    logic                  ram_we_q, ram_we_d;
    logic [AW-1:0]         ram_addr_q, ram_addr_d;
    logic [pixelWidth-1:0] ram_wdata_q, ram_wdata_d;
    logic                  busy_q, busy_d;
    logic                  host_ready_q, host_ready_d;
    logic                  done_q, done_d;

    logic in_mask, issue, ack_ok, last_issue;

    always_comb begin
        state_d       = state_q;
        load_addr_d   = load_addr_q;
        scan_addr_d   = scan_addr_q;
        sweep_done_d  = sweep_done_q;
        change_cnt_d  = change_cnt_q;
        pass_count_d  = pass_count_q;
        err_d         = err_q;
        mask_req_d    = 1'b0;
        mask_addr_d   = mask_addr_q;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        last_issue    = 1'b0;

        // A request is taken by the mask in the cycle mask_req is high.
        in_mask       = (state_q == StScan) || (state_q == StDrain);
        issue         = mask_req_q;
        ack_ok        = mask_ack && in_mask && ((outstanding_q != '0) || issue);
        outstanding_d = outstanding_q + OW'(issue) - OW'(ack_ok);

        if (ack_ok && mask_wr_valid) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = mask_wr_addr;
            ram_wdata_d = mask_wr_data;
            if (change_cnt_q != CntMax) begin
                change_cnt_d = change_cnt_q + 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StLoad;
                    pass_count_d = '0;
                    err_d        = 1'b0;
                    load_addr_d  = '0;
                    scan_addr_d  = '0;
                    sweep_done_d = 1'b0;
                    change_cnt_d = '0;
                end
            end
            StLoad: begin
                if (host_we) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = load_addr_q;
                    ram_wdata_d = host_data;
                    load_addr_d = load_addr_q + 1'b1;
                    if (load_addr_q == LastAddr) begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                if (issue && sweep_done_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (outstanding_q == '0) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                pass_count_d = pass_count_q + 8'd1;
                if ((ConvergeEn && (change_cnt_q == '0)) || (pass_count_d == MaxPasses)) begin
                    state_d = StDone;
                end else begin
                    change_cnt_d = '0;
                    scan_addr_d  = '0;
                    sweep_done_d = 1'b0;
                    state_d      = StScan;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Present the next address whenever the in-flight window has room after this edge.
        if ((state_d == StScan) && !sweep_done_d && (outstanding_d < MaxOut)) begin
            mask_req_d   = 1'b1;
            mask_addr_d  = scan_addr_d;
            last_issue   = (scan_addr_d == LastAddr);
            sweep_done_d = last_issue;
            scan_addr_d  = last_issue ? '0 : scan_addr_d + 1'b1;
        end

        // Errors are applied after the start clear so a same-cycle violation is kept.
        if (mask_ack && !ack_ok) begin
            err_d = 1'b1;
        end
        if (host_we && (state_q != StLoad)) begin
            err_d = 1'b1;
        end

        busy_d       = (state_d != StIdle);
        host_ready_d = (state_d == StLoad);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            load_addr_q   <= '0;
            scan_addr_q   <= '0;
            sweep_done_q  <= 1'b0;
            outstanding_q <= '0;
            change_cnt_q  <= '0;
            pass_count_q  <= '0;
            err_q         <= 1'b0;
            mask_req_q    <= 1'b0;
            mask_addr_q   <= '0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            busy_q        <= 1'b0;
            host_ready_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_addr_q   <= load_addr_d;
            scan_addr_q   <= scan_addr_d;
            sweep_done_q  <= sweep_done_d;
            outstanding_q <= outstanding_d;
            change_cnt_q  <= change_cnt_d;
            pass_count_q  <= pass_count_d;
            err_q         <= err_d;
            mask_req_q    <= mask_req_d;
            mask_addr_q   <= mask_addr_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            busy_q        <= busy_d;
            host_ready_q  <= host_ready_d;
            done_q        <= done_d;
        end
    end

    assign host_ready = host_ready_q;
    assign mask_req   = mask_req_q;
    assign mask_addr  = mask_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_count = pass_count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_skel_pass_scheduler.sv
// Directed bench for skel_pass_scheduler: behavioural mask with configurable latency and a RAM model.
`timescale 1ns/1ps

module tb_skel_pass_scheduler;

    localparam int NPix      = 64;
    localparam int MaxOut    = 4;
    localparam int MaxPasses = 3;
`ifdef SKEL_CONVERGE_EN
    localparam bit Conv = 1'b1;
`else
    localparam bit Conv = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_data = '0;
    logic       host_ready;
    logic       mask_req;
    logic [6:0] mask_addr;
    logic       m_ack = 1'b0;
    logic       spur_ack = 1'b0;
    logic       mask_ack;
    logic       mask_wr_valid = 1'b0;
    logic [6:0] mask_wr_addr = '0;
    logic [7:0] mask_wr_data = '0;
    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       busy;
    logic       done;
    logic [7:0] pass_count;
    logic       err;

    assign mask_ack = m_ack | spur_ack;

    skel_pass_scheduler #(
        .N          (8),
        .bitSize    (6),
        .pixelWidth (8),
        .MAX_PASSES (MaxPasses),
        .MAX_OUT    (MaxOut)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .host_we       (host_we),
        .host_data     (host_data),
        .host_ready    (host_ready),
        .mask_req      (mask_req),
        .mask_addr     (mask_addr),
        .mask_ack      (mask_ack),
        .mask_wr_valid (mask_wr_valid),
        .mask_wr_addr  (mask_wr_addr),
        .mask_wr_data  (mask_wr_data),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .busy          (busy),
        .done          (done),
        .pass_count    (pass_count),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mask model: acks each request lat cycles after issue; wr_mode selects write-backs.
    typedef struct {
        int addr;
        int due;
        int pass;
    } req_t;

    req_t q[$];
    req_t r;
    int   lat = 1;
    int   wr_mode = 0;
    int   cyc = 0;
    int   issue_cnt = 0;
    int   job_base = 0;
    int   order_err = 0;
    int   full_req_err = 0;
    int   full_cycles = 0;
    int   sz;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        m_ack = 1'b0;
        mask_wr_valid = 1'b0;
        if (!rst_n) begin
            q.delete();
            issue_cnt = 0;
            job_base = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) job_base = issue_cnt;
            busy_prev = busy;
            sz = q.size();
            if (mask_req) begin
                if (sz >= MaxOut) full_req_err++;
                if (int'(mask_addr) != (issue_cnt % NPix)) order_err++;
                q.push_back('{addr: int'(mask_addr), due: cyc + lat,
                              pass: (issue_cnt - job_base) / NPix});
                issue_cnt++;
            end else if (sz >= MaxOut) begin
                full_cycles++;
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                r = q.pop_front();
                m_ack = 1'b1;
                mask_wr_addr = 7'(r.addr);
                if (wr_mode == 1 && r.pass == 0 && (r.addr == 5 || r.addr == 17 || r.addr == 42)) begin
                    mask_wr_valid = 1'b1;
                    mask_wr_data = 8'(r.addr) ^ 8'hA0;
                end else if (wr_mode == 2 && r.addr == 9) begin
                    mask_wr_valid = 1'b1;
                    mask_wr_data = 8'h50 + 8'(r.pass);
                end
            end
        end
    end

    logic [7:0] ram [0:127];
    int ram_wr_cnt = 0;

    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            ram[ram_addr] = ram_wdata;
            ram_wr_cnt++;
        end
    end

    int last_full_cycles;

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("done_timeout", 0, 1);
    endtask

    task automatic start_and_load(input int base, input bit inj_start);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        check_eq("host_ready_after_start", host_ready, 1);
        check_eq("err_cleared_by_start", err, 0);
        for (int i = 0; i < NPix; i++) begin
            host_we = 1'b1;
            host_data = 8'(base + i);
            start = inj_start && (i == 10);
            @(negedge clk);
        end
        host_we = 1'b0;
        start = 1'b0;
        check_eq("first_req_valid", mask_req, 1);
        check_eq("first_req_addr", int'(mask_addr), 0);
        check_eq("host_ready_off_in_scan", host_ready, 0);
    endtask

    task automatic run_job(input int base, input int lat_v, input int mode_v,
                           input int exp_passes, input int exp_wr, input bit inject);
        int iss0, wr0, oe0, fr0, fc0;
        bit ok;
        lat = lat_v;
        wr_mode = mode_v;
        iss0 = issue_cnt;
        wr0 = ram_wr_cnt;
        oe0 = order_err;
        fr0 = full_req_err;
        fc0 = full_cycles;
        start_and_load(base, inject);
        if (inject) begin
            repeat (3) @(negedge clk);
            host_we = 1'b1;
            host_data = 8'hEE;
            @(negedge clk);
            host_we = 1'b0;
        end
        wait_done(ok);
        if (ok) begin
            check_eq("pass_count_at_done", int'(pass_count), exp_passes);
            check_eq("busy_at_done", busy, 1);
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
            check_eq("busy_falls_with_done", busy, 0);
        end
        check_eq("issue_count", issue_cnt - iss0, NPix * exp_passes);
        check_eq("issue_order_errors", order_err - oe0, 0);
        check_eq("req_while_full", full_req_err - fr0, 0);
        check_eq("ram_write_count", ram_wr_cnt - wr0, NPix + exp_wr);
        check_eq("err_at_end", err, int'(inject));
        last_full_cycles = full_cycles - fc0;
    endtask

    int mism;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_host_ready", host_ready, 0);
        check_eq("rst_mask_req", mask_req, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_pass_count", int'(pass_count), 0);
        rst_n = 1'b1;

        // Plain load of 0..63, no write-backs.
        run_job(0, 1, 0, Conv ? 1 : MaxPasses, 0, 1'b0);
        mism = 0;
        for (int i = 0; i < NPix; i++) if (int'(ram[i]) != i) mism++;
        check_eq("ram_load_identity", mism, 0);

        // Slow mask fills the window; three write-backs in the first pass only.
        run_job(200, 10, 1, Conv ? 2 : MaxPasses, 3, 1'b0);
        check_eq("stall_when_full", int'(last_full_cycles > 0), 1);
        check_eq("wb_addr5", int'(ram[5]), 8'hA5);
        check_eq("wb_addr17", int'(ram[17]), 8'hB1);
        check_eq("wb_addr42", int'(ram[42]), 8'h8A);
        check_eq("untouched_addr6", int'(ram[6]), 206);

        // A change every pass runs to the pass limit.
        run_job(7, 3, 2, MaxPasses, MaxPasses, 1'b0);
        check_eq("wb_last_pass_addr9", int'(ram[9]), 8'h52);
        check_eq("untouched_addr8", int'(ram[8]), 15);

        // Spurious ack while idle.
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        check_eq("spur_ack_err", err, 1);
        check_eq("spur_ack_no_write", ram_we, 0);

        // Start during LOAD and host_we during SCAN are both dropped.
        run_job(100, 2, 0, Conv ? 1 : MaxPasses, 0, 1'b1);
        mism = 0;
        for (int i = 0; i < NPix; i++) if (int'(ram[i]) != 100 + i) mism++;
        check_eq("ram_after_dropped_writes", mism, 0);

        // Reset mid-scan, then a full job.
        lat = 1;
        wr_mode = 0;
        start_and_load(50, 1'b0);
        repeat (5) @(negedge clk);
        host_we = 1'b1;
        host_data = 8'hEE;
        @(negedge clk);
        host_we = 1'b0;
        check_eq("err_host_we_in_scan", err, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_mask_req", mask_req, 0);
        check_eq("async_rst_ram_we", ram_we, 0);
        check_eq("async_rst_err", err, 0);
        check_eq("async_rst_host_ready", host_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_job(30, 1, 0, Conv ? 1 : MaxPasses, 0, 1'b0);
        mism = 0;
        for (int i = 0; i < NPix; i++) if (int'(ram[i]) != 30 + i) mism++;
        check_eq("ram_after_restart", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
